// File: rtl/fp_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fp_sched_pkg
// Brief    : Shared op encodings, scheduler states and FP constants.
// Revision : 1.0
// ============================================================================
package fp_sched_pkg;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_DIV = 2'b11;

   localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } sched_state_t;

   // Modular index step used by the round-robin search and pointer update.
   function automatic int wrap_add(input int base, input int off, input int n);
      return (base + off) % n;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fp_op_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : NREQ-way round-robin arbiter; pointer advances past the winner on en.
// Revision : 1.0
// ============================================================================
module rr_arbiter
   import fp_sched_pkg::*;
#(
   parameter int NREQ = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NREQ-1:0]         req,
   input  logic                    en,
   output logic [NREQ-1:0]         grant,
   output logic [$clog2(NREQ)-1:0] grant_idx,
   output logic                    any
);

   localparam int ID_W = $clog2(NREQ);

   logic [ID_W-1:0] r_ptr;
   logic [ID_W-1:0] w_idx;

   // Scan from the farthest offset down so the entry closest to the pointer wins.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any       = 1'b0;
      w_idx     = '0;
      for (int off = NREQ - 1; off >= 0; off--) begin
         w_idx = ID_W'(wrap_add(int'(r_ptr), off, NREQ));
         if (req[w_idx]) begin
            grant_idx = w_idx;
            any       = 1'b1;
         end
      end
      if (any) begin
         grant[grant_idx] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr <= '0;
      end else if (en && any) begin
         r_ptr <= ID_W'(wrap_add(int'(grant_idx), 1, NREQ));
      end
   end

endmodule
`default_nettype wire

// File: rtl/fp_op_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : fp_op_scheduler
// Brief    : Shares one FP datapath between NREQ requesters, one op in flight.
// Revision : 1.0
// ============================================================================
module fp_op_scheduler
   import fp_sched_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int NREQ    = 2,
   parameter int TIMEOUT = 64
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NREQ-1:0]          req_valid,
   output logic [NREQ-1:0]          req_ready,
   input  logic [2*NREQ-1:0]        req_op,
   input  logic [DATA_W*NREQ-1:0]   req_a,
   input  logic [DATA_W*NREQ-1:0]   req_b,
   output logic [1:0]               fpu_sel,
   output logic [DATA_W-1:0]        fpu_a,
   output logic [DATA_W-1:0]        fpu_b,
   output logic                     fpu_start,
   input  logic                     fpu_done,
   input  logic [DATA_W-1:0]        fpu_result,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [$clog2(NREQ)-1:0]  rsp_id,
   output logic [DATA_W-1:0]        rsp_data,
   output logic                     rsp_err
);

   localparam int ID_W  = $clog2(NREQ);
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   sched_state_t      r_state;
   sched_state_t      w_next;
   logic [CNT_W-1:0]  r_cnt;
   logic [NREQ-1:0]   w_grant;
   logic [ID_W-1:0]   w_gidx;
   logic              w_any;
   logic              w_accept;
   logic              w_timeout;

   logic [1:0]        w_op [NREQ];
   logic [DATA_W-1:0] w_a  [NREQ];
   logic [DATA_W-1:0] w_b  [NREQ];

   for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign w_op[gi] = req_op[2*gi +: 2];
      assign w_a[gi]  = req_a[DATA_W*gi +: DATA_W];
      assign w_b[gi]  = req_b[DATA_W*gi +: DATA_W];
   end

   rr_arbiter #(
      .NREQ      (NREQ)
   ) u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req_valid),
      .en        (w_accept),
      .grant     (w_grant),
      .grant_idx (w_gidx),
      .any       (w_any)
   );

   assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // req_ready is masked by rst_n so nothing is offered while reset is held.
   always_comb begin
      w_next    = r_state;
      w_accept  = 1'b0;
      req_ready = '0;
      fpu_start = 1'b0;
      rsp_valid = 1'b0;
      case (r_state)
         ST_IDLE: begin
            req_ready = w_grant & {NREQ{rst_n}};
            if (w_any) begin
               w_accept = 1'b1;
               w_next   = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            fpu_start = 1'b1;
            w_next    = ST_WAIT;
         end
         ST_WAIT: begin
            if (fpu_done || w_timeout) begin
               w_next = ST_RESP;
            end
         end
         ST_RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               w_next = ST_IDLE;
            end
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   // Operand and response registers only move on their own state's events.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fpu_sel  <= '0;
         fpu_a    <= '0;
         fpu_b    <= '0;
         rsp_id   <= '0;
         rsp_data <= '0;
         rsp_err  <= 1'b0;
         r_cnt    <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  fpu_sel <= w_op[w_gidx];
                  fpu_a   <= w_a[w_gidx];
                  fpu_b   <= w_b[w_gidx];
                  rsp_id  <= w_gidx;
               end
            end
            ST_ISSUE: begin
               r_cnt <= '0;
            end
            ST_WAIT: begin
               if (fpu_done) begin
                  rsp_data <= fpu_result;
                  rsp_err  <= 1'b0;
               end else if (w_timeout) begin
                  rsp_data <= DATA_W'(FP_QNAN);
                  rsp_err  <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
`default_nettype wire
